// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Load-use hazard tracker for the decode stage. Each GP register has a 3-bit
// down-counter. A load seen in EX/MA loads its target's counter with LOAD_LAT.
// The decode stage stalls while any operand it touches has a nonzero counter.
//
// Parameters
//   NUM_GP   : registers tracked (power of two, 2..64)
//   REG_W    : register index width, log2(NUM_GP)
//   LOAD_LAT : stall window per load (1..7)
//
// Ports
//   iw_clk            : clock, rising edge
//   iw_rst            : synchronous active-high reset
//   iw_exma_opc       : EX/MA opcode
//   iw_exma_tgt_gp    : EX/MA target register
//   iw_exma_tgt_gp_we : EX/MA target write enable
//   iw_src_a_gp       : decode source A register
//   iw_src_b_gp       : decode source B register
//   iw_src_b_use      : decode instruction reads source B
//   iw_tgt_gp         : decode target register
//   iw_flush          : pipeline flush, clears every counter
//   ow_stall          : decode stall request (combinational from counter state)
//   ow_pending        : per-register counter-nonzero flags
//   ow_stall_cnt      : 16-bit saturating count of stall cycles
//                       (present only when HAZARD_SCOREBOARD_PERF_EN is defined)
//
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN

`ifndef HBIT_OPC
`define HBIT_OPC 5
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_LDu 6'h0B
`endif

module hazard_scoreboard #(
  parameter int NUM_GP   = 16,
  parameter int REG_W    = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic [`HBIT_OPC:0]  iw_exma_opc,
  input  logic [REG_W-1:0]    iw_exma_tgt_gp,
  input  logic                iw_exma_tgt_gp_we,
  input  logic [REG_W-1:0]    iw_src_a_gp,
  input  logic [REG_W-1:0]    iw_src_b_gp,
  input  logic                iw_src_b_use,
  input  logic [REG_W-1:0]    iw_tgt_gp,
  input  logic                iw_flush,
  output logic                ow_stall,
  output logic [NUM_GP-1:0]   ow_pending
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [15:0]         ow_stall_cnt
`endif
);

  localparam logic [2:0] LAT_VAL = 3'(LOAD_LAT);

  logic [2:0] cnt_q [NUM_GP];
  logic       load_issue;

  assign load_issue = (iw_exma_opc == `OPC_RU_LDu) && iw_exma_tgt_gp_we;

  // Reset beats flush, flush beats load-issue. The loaded register takes
  // LOAD_LAT (retrigger); every other counter counts down toward zero.
  always_ff @(posedge iw_clk) begin
    if (iw_rst || iw_flush) begin
      for (int r = 0; r < NUM_GP; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else begin
      for (int r = 0; r < NUM_GP; r++) begin
        if (load_issue && (iw_exma_tgt_gp == REG_W'(r))) begin
          cnt_q[r] <= LAT_VAL;
        end else if (cnt_q[r] != 3'd0) begin
          cnt_q[r] <= cnt_q[r] - 3'd1;
        end
      end
    end
  end

  always_comb begin
    ow_pending = '0;
    for (int r = 0; r < NUM_GP; r++) begin
      ow_pending[r] = (cnt_q[r] != 3'd0);
    end
  end

  // Only registered state feeds the stall, so a load issuing this cycle
  // first stalls decode in the following cycle.
  assign ow_stall = ow_pending[iw_src_a_gp]
                  | (iw_src_b_use & ow_pending[iw_src_b_gp])
                  | ow_pending[iw_tgt_gp];

`ifdef HAZARD_SCOREBOARD_PERF_EN
  // Flush does not clear this counter; only reset does.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      ow_stall_cnt <= 16'd0;
    end else if (ow_stall && (ow_stall_cnt != 16'hFFFF)) begin
      ow_stall_cnt <= ow_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (NUM_GP=16, REG_W=4, LOAD_LAT=2).
// Each table row is one clock cycle: inputs held for the cycle and the
// stall / pending values expected during that cycle. Optional feature macro
// HAZARD_SCOREBOARD_PERF_EN enables the stall-counter sequence.

`ifndef HBIT_OPC
`define HBIT_OPC 5
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_LDu 6'h0B
`endif

module tb_hazard_scoreboard;

  logic               clk = 1'b0;
  logic               rst;
  logic [`HBIT_OPC:0] exma_opc;
  logic [3:0]         exma_tgt_gp;
  logic               exma_tgt_gp_we;
  logic [3:0]         src_a_gp;
  logic [3:0]         src_b_gp;
  logic               src_b_use;
  logic [3:0]         tgt_gp;
  logic               flush;
  logic               stall;
  logic [15:0]        pending;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [15:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [`HBIT_OPC:0] opc_ld;
  logic [`HBIT_OPC:0] opc_other;

  // clock / reset
  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_GP(16), .REG_W(4), .LOAD_LAT(2)) dut (
    .iw_clk            (clk),
    .iw_rst            (rst),
    .iw_exma_opc       (exma_opc),
    .iw_exma_tgt_gp    (exma_tgt_gp),
    .iw_exma_tgt_gp_we (exma_tgt_gp_we),
    .iw_src_a_gp       (src_a_gp),
    .iw_src_b_gp       (src_b_gp),
    .iw_src_b_use      (src_b_use),
    .iw_tgt_gp         (tgt_gp),
    .iw_flush          (flush),
    .ow_stall          (stall),
    .ow_pending        (pending)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    .ow_stall_cnt      (stall_cnt)
`endif
  );

  typedef struct {
    logic        ld;
    logic [3:0]  ld_tgt;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        b_use;
    logic [3:0]  tgt;
    logic        flush;
    logic        rst;
    logic        exp_stall;
    logic [15:0] exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int ld, input int ld_tgt, input int sa,
                              input int sb, input int bu, input int tg,
                              input int fl, input int rs, input int st,
                              input logic [15:0] pd);
    vec_t v;
    v.ld        = 1'(ld);
    v.ld_tgt    = 4'(ld_tgt);
    v.src_a     = 4'(sa);
    v.src_b     = 4'(sb);
    v.b_use     = 1'(bu);
    v.tgt       = 4'(tg);
    v.flush     = 1'(fl);
    v.rst       = 1'(rs);
    v.exp_stall = 1'(st);
    v.exp_pend  = pd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    rst            = 1'b0;
    exma_opc       = opc_other;
    exma_tgt_gp    = 4'd0;
    exma_tgt_gp_we = 1'b0;
    src_a_gp       = 4'd15;
    src_b_gp       = 4'd15;
    src_b_use      = 1'b0;
    tgt_gp         = 4'd15;
    flush          = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    rst            = v.rst;
    exma_opc       = v.ld ? opc_ld : opc_other;
    exma_tgt_gp    = v.ld_tgt;
    exma_tgt_gp_we = v.ld;
    src_a_gp       = v.src_a;
    src_b_gp       = v.src_b;
    src_b_use      = v.b_use;
    tgt_gp         = v.tgt;
    flush          = v.flush;
  endtask

  initial begin
    opc_ld    = `OPC_RU_LDu;
    opc_other = opc_ld ^ 6'h01;

    // ld, ld_tgt, src_a, src_b, b_use, tgt, flush, rst, exp_stall, exp_pend
    // single load, src_a held
    add(1, 3,  3, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(0, 0,  3, 15, 0, 15, 0, 0, 1, 16'h0008);
    add(0, 0,  3, 15, 0, 15, 0, 0, 1, 16'h0008);
    add(0, 0,  3, 15, 0, 15, 0, 0, 0, 16'h0000);
    // back-to-back loads to r1, r2 on src_a / src_b
    add(1, 1,  1,  2, 1, 15, 0, 0, 0, 16'h0000);
    add(1, 2,  1,  2, 1, 15, 0, 0, 1, 16'h0002);
    add(0, 0,  1,  2, 1, 15, 0, 0, 1, 16'h0006);
    add(0, 0,  1,  2, 1, 15, 0, 0, 1, 16'h0004);
    add(0, 0,  1,  2, 1, 15, 0, 0, 0, 16'h0000);
    // retrigger r5, decode target r5
    add(1, 5, 15, 15, 0,  5, 0, 0, 0, 16'h0000);
    add(1, 5, 15, 15, 0,  5, 0, 0, 1, 16'h0020);
    add(0, 0, 15, 15, 0,  5, 0, 0, 1, 16'h0020);
    add(0, 0, 15, 15, 0,  5, 0, 0, 1, 16'h0020);
    add(0, 0, 15, 15, 0,  5, 0, 0, 0, 16'h0000);
    // flush mid-window, then a load discarded by a flush
    add(1, 4,  4, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(0, 0,  4, 15, 0, 15, 1, 0, 1, 16'h0010);
    add(0, 0,  4, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(1, 7,  7, 15, 0, 15, 1, 0, 0, 16'h0000);
    add(0, 0,  7, 15, 0, 15, 0, 0, 0, 16'h0000);
    // source B match gated by b_use
    add(1, 6, 15,  6, 0, 15, 0, 0, 0, 16'h0000);
    add(0, 0, 15,  6, 0, 15, 0, 0, 0, 16'h0040);
    add(0, 0, 15,  6, 1, 15, 0, 0, 1, 16'h0040);
    add(0, 0, 15,  6, 1, 15, 0, 0, 0, 16'h0000);
    // reset mid-window, then reset beating a load
    add(1, 8,  8, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(0, 0,  8, 15, 0, 15, 0, 1, 1, 16'h0100);
    add(0, 0,  8, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(0, 0,  8, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(1, 9,  9, 15, 0, 15, 0, 1, 0, 16'h0000);
    add(0, 0,  9, 15, 0, 15, 0, 0, 0, 16'h0000);
    // three overlapping loads to distinct registers
    add(1, 10, 15, 15, 0, 15, 0, 0, 0, 16'h0000);
    add(1, 11, 15, 15, 0, 15, 0, 0, 0, 16'h0400);
    add(1, 12, 15, 15, 0, 15, 0, 0, 0, 16'h0C00);
    add(0, 0,  12, 15, 0, 15, 0, 0, 1, 16'h1800);
    add(0, 0,  12, 15, 0, 15, 0, 0, 1, 16'h1000);
    add(0, 0,  12, 15, 0, 15, 0, 0, 0, 16'h0000);

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
      @(posedge clk);
      #1;
    end

    // Not a load-issue: load opcode without write enable, then write enable
    // with a different opcode.
    drive_idle();
    exma_opc = opc_ld; exma_tgt_gp = 4'd13; exma_tgt_gp_we = 1'b0; src_a_gp = 4'd13;
    @(posedge clk); #1;
    exma_opc = opc_other; exma_tgt_gp_we = 1'b1;
    @(negedge clk);
    check("ld_no_we_stall", 32'(stall), 32'd0);
    check("ld_no_we_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    drive_idle();
    src_a_gp = 4'd13;
    @(negedge clk);
    check("non_ld_stall", 32'(stall), 32'd0);
    check("non_ld_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    // Retrigger r0 every cycle with src_a=r0 to force continuous stall.
    drive_idle();
    exma_opc = opc_ld; exma_tgt_gp = 4'd0; exma_tgt_gp_we = 1'b1; src_a_gp = 4'd0;
    repeat (70001) @(posedge clk);
    #1;
    @(negedge clk);
    check("perf_saturate", 32'(stall_cnt), 32'hFFFF);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("perf_after_flush", 32'(stall_cnt), 32'hFFFF);
    check("perf_flush_pending", 32'(pending), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("perf_after_reset", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
